// File: rtl/fifo_rd_stream.sv
// Read-side FIFO drain into a registered valid/ready stream via a 2-entry skid buffer.
// Optional delivery counter enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  R_CLK,
   input  logic                  R_rst_n,
   input  logic                  F_Empty,
   input  logic [DATA_WIDTH-1:0] F_Data,
   output logic                  F_inc,
   input  logic                  Flush,
   output logic                  M_Valid,
   output logic [DATA_WIDTH-1:0] M_Data,
   input  logic                  M_Ready,
   output logic [CNT_WIDTH-1:0]  Rd_Count
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [DATA_WIDTH-1:0] w_head_nxt;
   logic [DATA_WIDTH-1:0] w_tail_nxt;
   logic                  w_pop;
   logic                  w_take;

   // Pop depends only on registered flag/state, so there is no path from M_Ready.
   // Held off during reset so nothing is popped until R_rst_n releases.
   assign w_pop   = ~F_Empty & (r_state != S_FULL) & ~Flush & R_rst_n;
   assign w_take  = M_Valid & M_Ready;
   assign F_inc   = w_pop;
   assign M_Valid = (r_state != S_EMPTY);
   assign M_Data  = r_head;

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      if (Flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_pop) begin
                  w_state_nxt = S_ONE;
                  w_head_nxt  = F_Data;
               end
            end
            S_ONE: begin
               if (w_pop && !w_take) begin
                  w_state_nxt = S_FULL;
                  w_tail_nxt  = F_Data;
               end else if (w_pop && w_take) begin
                  w_head_nxt  = F_Data;
               end else if (w_take) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_take) begin
                  w_state_nxt = S_ONE;
                  w_head_nxt  = r_tail;
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge R_CLK or negedge R_rst_n) begin
      if (!R_rst_n) begin
         r_state <= S_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
      end
   end

`ifdef FIFO_RD_STATS_EN
   logic [CNT_WIDTH-1:0] r_rd_count;

   // A take coinciding with Flush is discarded, not delivered.
   always_ff @(posedge R_CLK or negedge R_rst_n) begin
      if (!R_rst_n) begin
         r_rd_count <= '0;
      end else if (w_take && !Flush) begin
         r_rd_count <= r_rd_count + 1'b1;
      end
   end

   assign Rd_Count = r_rd_count;
`else
   assign Rd_Count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based FIFO/skid model plus directed scenarios.
module tb_fifo_rd_stream;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          R_CLK = 1'b0;
   logic          R_rst_n;
   logic          F_Empty;
   logic [DW-1:0] F_Data;
   logic          F_inc;
   logic          Flush;
   logic          M_Valid;
   logic [DW-1:0] M_Data;
   logic          M_Ready;
   logic [CW-1:0] Rd_Count;

   fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .R_CLK   (R_CLK),
      .R_rst_n (R_rst_n),
      .F_Empty (F_Empty),
      .F_Data  (F_Data),
      .F_inc   (F_inc),
      .Flush   (Flush),
      .M_Valid (M_Valid),
      .M_Data  (M_Data),
      .M_Ready (M_Ready),
      .Rd_Count(Rd_Count)
   );

   always #5 R_CLK = ~R_CLK;

   int            n_cmp  = 0;
   int            n_fail = 0;
   int            m_cnt  = 0;
   int            inc_cnt = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] mbuf[$];
   logic [DW-1:0] dlog[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_RD_STATS_EN
      logic [CW-1:0] v;
      v = n[CW-1:0];
      return 32'(v);
`else
      return (n < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   task automatic drive_fifo();
      F_Empty = (fifo_q.size() == 0);
      F_Data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // One clock: drive inputs after negedge, check pop, advance model at posedge, check outputs at negedge.
   task automatic step(input logic rdy, input logic fl);
      logic m_pop;
      logic m_take;
      M_Ready = rdy;
      Flush   = fl;
      drive_fifo();
      #1;
      m_pop  = !F_Empty && (mbuf.size() < 2) && !fl;
      m_take = (mbuf.size() > 0) && rdy;
      check("F_inc", 32'(F_inc), 32'(m_pop));
      if (F_inc) inc_cnt++;
      if (M_Valid && M_Ready && !Flush) dlog.push_back(M_Data);
      @(posedge R_CLK);
      if (fl) begin
         mbuf.delete();
      end else begin
         if (m_take) begin
            void'(mbuf.pop_front());
            m_cnt++;
         end
         if (m_pop) mbuf.push_back(fifo_q.pop_front());
      end
      @(negedge R_CLK);
      check("M_Valid", 32'(M_Valid), 32'(mbuf.size() > 0));
      if (mbuf.size() > 0) check("M_Data", 32'(M_Data), 32'(mbuf[0]));
      check("Rd_Count", 32'(Rd_Count), exp_cnt(m_cnt));
   endtask

   initial begin
      R_rst_n = 1'b0;
      M_Ready = 1'b0;
      Flush   = 1'b0;
      drive_fifo();
      @(negedge R_CLK);
      @(negedge R_CLK);
      check("rst_M_Valid", 32'(M_Valid), 32'd0);
      check("rst_M_Data", 32'(M_Data), 32'd0);
      check("rst_F_inc", 32'(F_inc), 32'd0);
      check("rst_Rd_Count", 32'(Rd_Count), 32'd0);
      R_rst_n = 1'b1;

      // Preloaded three words, sink always ready.
      fifo_q = '{8'h11, 8'h22, 8'h33};
      dlog.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("t1_len", 32'(dlog.size()), 32'd3);
      if (dlog.size() == 3) begin
         check("t1_w0", 32'(dlog[0]), 32'h11);
         check("t1_w1", 32'(dlog[1]), 32'h22);
         check("t1_w2", 32'(dlog[2]), 32'h33);
      end
      check("t1_valid_off", 32'(M_Valid), 32'd0);
      check("t1_count", 32'(Rd_Count), exp_cnt(3));

      // Backpressure with five words queued.
      fifo_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
      dlog.delete();
      inc_cnt = 0;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      check("t2_pops", 32'(inc_cnt), 32'd2);
      check("t2_valid", 32'(M_Valid), 32'd1);
      check("t2_hold", 32'(M_Data), 32'h40);
      for (int i = 0; i < 20 && dlog.size() < 5; i++) step(1'b1, 1'b0);
      check("t2_len", 32'(dlog.size()), 32'd5);
      for (int i = 0; i < 5 && i < dlog.size(); i++) check("t2_order", 32'(dlog[i]), 32'(8'h40 + i));

      // Ready toggling every cycle over a 16-word stream.
      fifo_q.delete();
      for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
      dlog.delete();
      for (int i = 0; i < 100 && dlog.size() < 16; i++) step(1'((i % 2) == 0), 1'b0);
      check("t3_len", 32'(dlog.size()), 32'd16);
      for (int i = 0; i < 16 && i < dlog.size(); i++) check("t3_order", 32'(dlog[i]), 32'(i));
      check("t3_count", 32'(Rd_Count), exp_cnt(24));

      // Flush while FULL, with ready asserted on the same cycle.
      fifo_q = '{8'hA0, 8'hA1, 8'hA2};
      dlog.delete();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check("t4_full_head", 32'(M_Data), 32'hA0);
      step(1'b1, 1'b1);
      check("t4_valid_off", 32'(M_Valid), 32'd0);
      check("t4_count", 32'(Rd_Count), exp_cnt(24));
      check("t4_flush_nodeliv", 32'(dlog.size()), 32'd0);
      for (int i = 0; i < 10 && dlog.size() < 1; i++) step(1'b1, 1'b0);
      check("t4_len", 32'(dlog.size()), 32'd1);
      if (dlog.size() > 0) check("t4_next", 32'(dlog[0]), 32'hA2);

      // Empty FIFO, then a single late word.
      inc_cnt = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("t5_no_pop", 32'(inc_cnt), 32'd0);
      check("t5_valid_off", 32'(M_Valid), 32'd0);
      fifo_q.push_back(8'h5A);
      step(1'b1, 1'b0);
      check("t5_valid", 32'(M_Valid), 32'd1);
      check("t5_data", 32'(M_Data), 32'h5A);
      step(1'b1, 1'b0);
      check("t5_count", 32'(Rd_Count), exp_cnt(26));

      // Asynchronous reset while FULL.
      fifo_q = '{8'h60, 8'h61, 8'h62, 8'h63};
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("t6_full_valid", 32'(M_Valid), 32'd1);
      #2;
      R_rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(M_Valid), 32'd0);
      check("t6_async_count", 32'(Rd_Count), 32'd0);
      check("t6_async_inc", 32'(F_inc), 32'd0);
      mbuf.delete();
      fifo_q.delete();
      m_cnt = 0;
      drive_fifo();
      @(negedge R_CLK);
      @(negedge R_CLK);
      R_rst_n = 1'b1;
      step(1'b1, 1'b0);
      fifo_q.push_back(8'h77);
      dlog.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("t6_recover_len", 32'(dlog.size()), 32'd1);
      if (dlog.size() > 0) check("t6_recover_data", 32'(dlog[0]), 32'h77);
      check("t6_recover_count", 32'(Rd_Count), exp_cnt(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the asynchronous CDC FIFO, living entirely in the read clock domain. Drains the FIFO read port (`Empty` / `R_inc` / `R_Data`) into a registered valid/ready stream through a 2-entry skid buffer. Downstream logic sees registered data and a clean backpressure handshake. Full throughput is sustained when the sink never stalls.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width; must match the FIFO instance.
- `CNT_WIDTH`, default 16: width of the statistics counter (`FIFO_RD_STATS_EN` only).

- `R_CLK` input 1: read-domain clock, rising edge.
- `R_rst_n` input 1: asynchronous, active-low reset.
- `F_Empty` input 1: FIFO `Empty` flag (registered in the FIFO, synchronous to `R_CLK`).
- `F_Data` input DATA_WIDTH: FIFO `R_Data`; reflects the current read address combinationally.
- `F_inc` output 1: to FIFO `R_inc`; pops one word at the next `R_CLK` edge.
- `Flush` input 1: synchronous clear of the skid buffer.
- `M_Valid` output 1: output word is available.
- `M_Data` output DATA_WIDTH: output word (head of the skid buffer).
- `M_Ready` input 1: sink accepts `M_Data` this cycle.
- `Rd_Count` output CNT_WIDTH: words delivered to the sink (`FIFO_RD_STATS_EN` only).

## Operation
- Skid buffer has two registers (`head`, `tail`) and an occupancy state: EMPTY (0), ONE (1), FULL (2).
- Pop: `F_inc = ~F_Empty & (state != FULL) & ~Flush`. This is combinational from a registered flag and state, so there is no loop through `M_Ready`.
- Take: `take = M_Valid & M_Ready`.
- `M_Valid = (state != EMPTY)` and `M_Data = head`. Both are driven directly from registers.
- State transitions on each edge, by (pop, take):
  - EMPTY: pop → ONE, `head ← F_Data`.
  - ONE: pop & !take → FULL, `tail ← F_Data`. pop & take → ONE, `head ← F_Data`. !pop & take → EMPTY. Neither → hold.
  - FULL: take → ONE, `head ← tail`. There is no pop in FULL.
- Flush: next state is EMPTY, no pop that cycle, and buffered words are discarded. Flush takes priority over take; a take in the same cycle does not count as a delivery.
- `head` and `tail` are not cleared by Flush. Their contents are don't-care while invalid.
- Ordering is strict FIFO. No word is duplicated or dropped except by Flush.

## Timing
- Reset values: state EMPTY, `M_Valid` 0, `M_Data` 0, `F_inc` 0 while `F_Empty` is 1, `Rd_Count` 0.
- Reset is asynchronous assert. Deassertion is synchronized externally (the FIFO read-side reset).
- Latency: a word popped at edge N is on `M_Data` with `M_Valid` = 1 after edge N (1 cycle).
- Throughput: with `M_Ready` held at 1 and the FIFO non-empty, there is one pop and one take per cycle, and the state stays in ONE.
- Backpressure: after `M_Ready` drops, at most one more word is popped (ONE→FULL). Then `F_inc` stays 0 until a take occurs.
- `M_Valid` and `M_Data` are held stable while `M_Valid & ~M_Ready`.
- When `F_Empty` rises, the in-flight pop is already excluded because `F_inc` is gated by `F_Empty` in the same cycle.
- Reset mid-operation: buffered words are lost and the FIFO pointers reset independently. No further pop occurs until `R_rst_n` releases.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `Rd_Count` increments by 1 on every take (not on flushed words).
  - It wraps modulo 2^CNT_WIDTH and resets to 0.
- `FIFO_RD_STATS_EN` undefined: `Rd_Count` is tied to 0 and no counter logic is generated.

## Test plan
- Reset, then FIFO preloaded with 0x11, 0x22, 0x33 and `M_Ready` = 1 → `M_Data` shows 0x11, 0x22, 0x33 on three consecutive cycles. `M_Valid` deasserts the cycle after 0x33; `Rd_Count` = 3.
- `M_Ready` = 0 with FIFO holding 5 words → exactly 2 pops (`F_inc` high 2 cycles), state FULL, `M_Data` = word0 held stable. Release `M_Ready` → all 5 words delivered in order.
- Toggle `M_Ready` 1/0 every cycle with a 16-word stream 0x00..0x0F → output sequence is exactly 0x00..0x0F, with no duplicates or gaps.
- In state FULL (0xA0, 0xA1), assert `Flush` together with `M_Ready` = 1 → next cycle `M_Valid` = 0 and `Rd_Count` is unchanged. The following FIFO word 0xA2 is the next output.
- FIFO empty (`F_Empty` = 1) → `F_inc` never asserts and `M_Valid` stays 0. A single word 0x5A written on the write side appears after synchronizer delay, 1 cycle after `F_Empty` falls.
- Assert `R_rst_n` = 0 asynchronously mid-stream in FULL → `M_Valid` is 0 and `Rd_Count` is 0 immediately, without waiting for a clock edge.
